// File: rtl/ram_ctrl_if.sv
// Handshake bus between a requester (master) and the ram_ctrl word RAM (slave).
interface ram_ctrl_if;
    logic        ram_txs;
    logic        ram_re;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [31:0] ram_in;
    logic [31:0] ram_out;
    logic        ram_txe;
    logic        ram_err;

    modport master (
        output ram_txs, ram_re, ram_we, ram_addr, ram_in,
        input  ram_out, ram_txe, ram_err
    );

    modport slave (
        input  ram_txs, ram_re, ram_we, ram_addr, ram_in,
        output ram_out, ram_txe, ram_err
    );
endinterface

// File: rtl/ram_ctrl.sv
// Single-port 32-bit word RAM behind an arm/start/done strobe handshake.
// Define RAM_CTRL_BOUNDS_CHECK_EN to reject addresses with nonzero upper bits.
module ram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input logic     clk,
    input logic     rst,
    ram_ctrl_if.slave bus
);
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    // Preload so ram_txe rises LATENCY+1 edges after the start edge.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, ARMED, BUSY, DONE} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  txe_q;
    logic [31:0]           out_q;

    logic                  re_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           rd_val;
    logic                  blocked;
    logic                  start;
    logic                  finish;
    logic                  do_write;

    function automatic logic upper_nonzero(input logic [63:0] a);
        return |(a >> ADDR_WIDTH);
    endfunction

    assign start    = (state_q == ARMED) && bus.ram_txs;
    assign finish   = (state_q == BUSY) && (cnt_q == 4'd0);
    assign do_write = finish && we_q && !blocked && !rst;

`ifdef RAM_CTRL_BOUNDS_CHECK_EN
    logic oob_q;
    logic err_q;

    always_ff @(posedge clk) begin
        if (start) begin
            oob_q <= upper_nonzero(bus.ram_addr);
        end
    end

    assign blocked     = oob_q;
    assign bus.ram_err = err_q;

    always_comb begin
        rd_val = mem[addr_q];
        if (oob_q) begin
            rd_val = 32'hDEAD_BEEF;
        end
    end
`else
    // Upper address bits wrap silently when the range check is compiled out.
    logic unused_addr_hi;

    assign unused_addr_hi = upper_nonzero(bus.ram_addr);
    assign blocked        = 1'b0;
    assign bus.ram_err    = 1'b0;
    assign rd_val         = mem[addr_q];
`endif

    assign bus.ram_txe = txe_q;
    assign bus.ram_out = out_q;

    // Transaction fields are captured once at start and ignored afterwards.
    always_ff @(posedge clk) begin
        if (start) begin
            re_q    <= bus.ram_re;
            we_q    <= bus.ram_we;
            addr_q  <= bus.ram_addr[ADDR_WIDTH-1:0];
            wdata_q <= bus.ram_in;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            txe_q   <= 1'b1;
            out_q   <= 32'd0;
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!bus.ram_txs) begin
                        state_q <= ARMED;
                        txe_q   <= 1'b0;
                    end
                end
                ARMED: begin
                    if (bus.ram_txs) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        txe_q   <= 1'b1;
                        // rd_val is the pre-write word, giving read-before-write.
                        if (re_q) begin
                            out_q <= rd_val;
                        end
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
                        err_q <= oob_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (!bus.ram_txs) begin
                        state_q <= ARMED;
                        txe_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txe_q   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_ctrl.sv
// Directed plus randomized bench for ram_ctrl with an array-based reference model.
module tb_ram_ctrl;
    localparam int ADDR_WIDTH = 10;
    localparam int LAT        = 2;
`ifdef RAM_CTRL_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] model_mem [1 << ADDR_WIDTH];
    logic [31:0] model_out;

    ram_ctrl_if bus ();

    ram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    // One full handshake starting from IDLE or DONE with ram_txs held high.
    task automatic do_txn(input logic re, input logic we, input logic [63:0] a, input logic [31:0] d);
        int          n;
        logic        oob;
        logic [9:0]  idx;
        logic [31:0] exp_out;

        oob     = BOUNDS && (a[63:ADDR_WIDTH] != 54'd0);
        idx     = a[ADDR_WIDTH-1:0];
        exp_out = model_out;
        if (re) exp_out = oob ? 32'hDEAD_BEEF : model_mem[idx];

        @(negedge clk);
        bus.ram_txs = 1'b0;
        @(negedge clk);
        chk("armed_txe", {63'd0, bus.ram_txe}, 64'd0);
        bus.ram_txs  = 1'b1;
        bus.ram_re   = re;
        bus.ram_we   = we;
        bus.ram_addr = a;
        bus.ram_in   = d;
        @(posedge clk);
        #1;
        bus.ram_re   = 1'($urandom);
        bus.ram_we   = 1'($urandom);
        bus.ram_addr = {32'($urandom), 32'($urandom)};
        bus.ram_in   = 32'($urandom);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ram_txe === 1'b1) break;
        end
        chk("latency", 64'(n), 64'(LAT + 1));
        chk("ram_out", {32'd0, bus.ram_out}, {32'd0, exp_out});
        chk("err_pulse", {63'd0, bus.ram_err}, {63'd0, oob});
        @(posedge clk);
        #1;
        chk("err_clear", {63'd0, bus.ram_err}, 64'd0);
        chk("done_hold", {63'd0, bus.ram_txe}, 64'd1);

        if (we && !oob) model_mem[idx] = d;
        model_out = exp_out;
    endtask

    initial begin
        logic [63:0] a;
        logic [31:0] d;
        logic        re;
        logic        we;

        checks       = 0;
        failures     = 0;
        model_out    = 32'd0;
        rst          = 1'b1;
        bus.ram_txs  = 1'b1;
        bus.ram_re   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = 64'd0;
        bus.ram_in   = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txe", {63'd0, bus.ram_txe}, 64'd1);
        chk("rst_out", {32'd0, bus.ram_out}, 64'd0);
        chk("rst_err", {63'd0, bus.ram_err}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold_txe", {63'd0, bus.ram_txe}, 64'd1);

        // Basic write then read-back of address 5.
        do_txn(1'b1 ^ 1'b1, 1'b1, 64'd5, 32'h1234_5678);
        do_txn(1'b1, 1'b0, 64'd5, 32'h0);
        chk("rd5", {32'd0, bus.ram_out}, 64'h1234_5678);

        // Fill a small window so every later read hits defined data.
        for (int i = 0; i < 16; i++) begin
            if (i != 5) do_txn(1'b0, 1'b1, 64'(i), (i == 9) ? 32'd0 : 32'($urandom));
        end
        do_txn(1'b0, 1'b1, 64'd7, 32'hAAAA_0000);

        // Back-to-back read of address 6 from DONE.
        do_txn(1'b1, 1'b0, 64'd6, 32'h0);

        // Simultaneous read and write returns the old word.
        do_txn(1'b1, 1'b1, 64'd7, 32'h5555_FFFF);
        chk("rbw_old", {32'd0, bus.ram_out}, 64'hAAAA_0000);
        do_txn(1'b1, 1'b0, 64'd7, 32'h0);
        chk("rbw_new", {32'd0, bus.ram_out}, 64'h5555_FFFF);

        // Neither read nor write: output held, handshake still completes.
        do_txn(1'b0, 1'b0, 64'd3, 32'hFFFF_FFFF);

        // Reset while a write to address 9 is in flight.
        @(negedge clk);
        bus.ram_txs = 1'b0;
        @(negedge clk);
        bus.ram_txs  = 1'b1;
        bus.ram_re   = 1'b0;
        bus.ram_we   = 1'b1;
        bus.ram_addr = 64'd9;
        bus.ram_in   = 32'hCAFE_BABE;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("busy_txe", {63'd0, bus.ram_txe}, 64'd0);
        rst = 1'b1;
        #1;
        chk("abort_txe", {63'd0, bus.ram_txe}, 64'd1);
        chk("abort_out", {32'd0, bus.ram_out}, 64'd0);
        chk("abort_err", {63'd0, bus.ram_err}, 64'd0);
        model_out = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_txn(1'b1, 1'b0, 64'd9, 32'h0);
        chk("rd9_after_abort", {32'd0, bus.ram_out}, 64'd0);

        // Upper address bits set.
        do_txn(1'b1, 1'b0, 64'h400, 32'h0);
        do_txn(1'b0, 1'b1, 64'h0000_0001_0000_0002, 32'h0BAD_F00D);
        do_txn(1'b1, 1'b0, 64'd2, 32'h0);

        // Randomized traffic over the initialized window.
        for (int k = 0; k < 40; k++) begin
            re = 1'($urandom);
            we = 1'($urandom);
            a  = 64'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a[40 +: 8] = 8'($urandom_range(1, 255));
            d  = 32'($urandom);
            do_txn(re, we, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
